// File: rtl/cmp_pkg.sv
// Shared definitions for the comparator arbiter slice.
// Contents:
//   state_t        - arbiter FSM encoding (IDLE / EXEC / RESP)
//   OP_EQ..OP_MAX  - 2-bit opcode constants understood by cmp_unit
package cmp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [1:0] OP_EQ  = 2'b00;
  localparam logic [1:0] OP_GT  = 2'b01;
  localparam logic [1:0] OP_LT  = 2'b10;
  localparam logic [1:0] OP_MAX = 2'b11;

endpackage

// File: rtl/cmp_unit.sv
// Purely combinational 4-bit unsigned compare/max unit.
// Ports:
//   op  [1:0] in  - operation (OP_EQ, OP_GT, OP_LT, OP_MAX)
//   x   [3:0] in  - operand x
//   y   [3:0] in  - operand y
//   res [3:0] out - flag in bit 0 for compares, larger operand for MAX
module cmp_unit
  import cmp_pkg::*;
(
  input  logic [1:0] op,
  input  logic [3:0] x,
  input  logic [3:0] y,
  output logic [3:0] res
);

  always_comb begin
    res = 4'b0;
    case (op)
      OP_EQ:   res = {3'b0, (x == y)};
      OP_GT:   res = {3'b0, (x > y)};
      OP_LT:   res = {3'b0, (x < y)};
      // Ties resolve to x.
      default: res = (y > x) ? y : x;
    endcase
  end

endmodule

// File: rtl/cmp_arbiter.sv
// Two-requester arbiter in front of a single shared comparator.
// One op is in flight at a time: IDLE (grant/accept) -> EXEC (compute into
// result register) -> RESP (hold result for the owner until it is taken).
// Ports:
//   clk, reset                     - clock, synchronous active-high reset
//   reqN_valid/op/x/y, reqN_ready  - request channel N (ready = accepted now)
//   rspN_valid/data, rspN_ready    - response channel N (owner only)
//   busy                           - an op is in flight
//   op_count [7:0]                 - completed ops, wraps 255 -> 0
module cmp_arbiter
  import cmp_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       req0_valid,
  input  logic [1:0] req0_op,
  input  logic [3:0] req0_x,
  input  logic [3:0] req0_y,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [1:0] req1_op,
  input  logic [3:0] req1_x,
  input  logic [3:0] req1_y,
  output logic       req1_ready,
  output logic       rsp0_valid,
  output logic [3:0] rsp0_data,
  input  logic       rsp0_ready,
  output logic       rsp1_valid,
  output logic [3:0] rsp1_data,
  input  logic       rsp1_ready,
  output logic       busy,
  output logic [7:0] op_count
);

  state_t     state_reg, state_next;
  logic       prio_reg;
  logic       owner_reg;
  logic [1:0] op_reg;
  logic [3:0] x_reg, y_reg;
  logic [3:0] result_reg;
  logic [7:0] op_count_reg;

  logic       any_valid;
  logic       grant_id;
  logic       owner_rsp_ready;
  logic [3:0] cmp_res;
  logic       in_idle, in_resp;
  logic [1:0] req_ready_vec, rsp_valid_vec;

  // Only a contested cycle consults prio; a lone requester always wins.
  assign any_valid       = req0_valid | req1_valid;
  assign grant_id        = (req0_valid & req1_valid) ? prio_reg : req1_valid;
  assign owner_rsp_ready = owner_reg ? rsp1_ready : rsp0_ready;

  cmp_unit u_cmp (
    .op  (op_reg),
    .x   (x_reg),
    .y   (y_reg),
    .res (cmp_res)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_reg <= ST_IDLE;
    else       state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (any_valid) state_next = ST_EXEC;
      ST_EXEC: state_next = ST_RESP;
      ST_RESP: if (owner_rsp_ready) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Output decode. Ready is masked during reset so a requester never sees an
  // acceptance that the reset is about to discard.
  always_comb begin
    in_idle = (state_reg == ST_IDLE) & ~reset;
    in_resp = (state_reg == ST_RESP);
    busy    = (state_reg != ST_IDLE);
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_chan
      assign req_ready_vec[gi] = in_idle & any_valid & (grant_id == gi[0]);
      assign rsp_valid_vec[gi] = in_resp & (owner_reg == gi[0]);
    end
  endgenerate

  assign req0_ready = req_ready_vec[0];
  assign req1_ready = req_ready_vec[1];
  assign rsp0_valid = rsp_valid_vec[0];
  assign rsp1_valid = rsp_valid_vec[1];
  assign rsp0_data  = rsp_valid_vec[0] ? result_reg : 4'b0;
  assign rsp1_data  = rsp_valid_vec[1] ? result_reg : 4'b0;
  assign op_count   = op_count_reg;

  // Datapath: operand capture on accept, result capture in EXEC, bookkeeping
  // on completion.
  always_ff @(posedge clk) begin
    if (reset) begin
      prio_reg     <= 1'b0;
      owner_reg    <= 1'b0;
      op_reg       <= 2'b0;
      x_reg        <= 4'b0;
      y_reg        <= 4'b0;
      result_reg   <= 4'b0;
      op_count_reg <= 8'd0;
    end else begin
      case (state_reg)
        ST_IDLE: if (any_valid) begin
          owner_reg <= grant_id;
          op_reg    <= grant_id ? req1_op : req0_op;
          x_reg     <= grant_id ? req1_x  : req0_x;
          y_reg     <= grant_id ? req1_y  : req0_y;
        end
        ST_EXEC: result_reg <= cmp_res;
        ST_RESP: if (owner_rsp_ready) begin
          prio_reg     <= ~owner_reg;
          op_count_reg <= op_count_reg + 8'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cmp_arbiter.sv
// Directed bench for cmp_arbiter: a table of single ops with hand-computed
// results, then hand-written contention, backpressure, reset and wrap cases.
module tb_cmp_arbiter;
  import cmp_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] req_valid;
  logic [1:0] req_op [2];
  logic [3:0] req_x  [2];
  logic [3:0] req_y  [2];
  logic [1:0] req_ready;
  logic [1:0] rsp_valid;
  logic [3:0] rsp_data [2];
  logic [1:0] rsp_ready;
  logic       busy;
  logic [7:0] op_count;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] exp_count;

  always #5 clk = ~clk;

  cmp_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req_valid[0]),
    .req0_op    (req_op[0]),
    .req0_x     (req_x[0]),
    .req0_y     (req_y[0]),
    .req0_ready (req_ready[0]),
    .req1_valid (req_valid[1]),
    .req1_op    (req_op[1]),
    .req1_x     (req_x[1]),
    .req1_y     (req_y[1]),
    .req1_ready (req_ready[1]),
    .rsp0_valid (rsp_valid[0]),
    .rsp0_data  (rsp_data[0]),
    .rsp0_ready (rsp_ready[0]),
    .rsp1_valid (rsp_valid[1]),
    .rsp1_data  (rsp_data[1]),
    .rsp1_ready (rsp_ready[1]),
    .busy       (busy),
    .op_count   (op_count)
  );

  typedef struct {
    int         id;
    logic [1:0] op;
    logic [3:0] x;
    logic [3:0] y;
    logic [3:0] exp_res;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    exp_count = 8'd0;
  endtask

  // One complete op on requester id, ready for the response held high.
  task automatic do_op(input int id, input logic [1:0] op, input logic [3:0] x,
                       input logic [3:0] y, input logic [3:0] exp_res, input bit verbose);
    req_valid[id] = 1'b1;
    req_op[id]    = op;
    req_x[id]     = x;
    req_y[id]     = y;
    rsp_ready     = 2'b11;
    #1;
    check("accept_ready", req_ready[id], 1);
    step();                                   // accept edge T
    req_valid[id] = 1'b0;
    #1;
    check("exec_busy", busy, 1);
    check("exec_no_rsp", rsp_valid, 0);
    step();                                   // T+1: EXEC -> RESP
    check("rsp_valid", rsp_valid, (id == 0) ? 1 : 2);
    check("rsp_data", rsp_data[id], exp_res);
    step();                                   // T+2: response taken
    exp_count = exp_count + 8'd1;
    check("op_count", op_count, exp_count);
    check("idle_busy", busy, 0);
    if (verbose)
      $display("op id=%0d op=%0d x=%0d y=%0d -> res=%0d count=%0d",
               id, op, x, y, exp_res, exp_count);
  endtask

  initial begin
    vecs[0]  = '{0, OP_MAX, 4'd5,  4'd9,  4'd9};
    vecs[1]  = '{1, OP_EQ,  4'd7,  4'd7,  4'd1};
    vecs[2]  = '{1, OP_GT,  4'd3,  4'd12, 4'd0};
    vecs[3]  = '{1, OP_LT,  4'd3,  4'd12, 4'd1};
    vecs[4]  = '{1, OP_MAX, 4'd6,  4'd6,  4'd6};
    vecs[5]  = '{0, OP_MAX, 4'd9,  4'd5,  4'd9};
    vecs[6]  = '{1, OP_MAX, 4'd0,  4'd15, 4'd15};
    vecs[7]  = '{0, OP_GT,  4'd15, 4'd0,  4'd1};
    vecs[8]  = '{0, OP_EQ,  4'd0,  4'd15, 4'd0};
    vecs[9]  = '{1, OP_LT,  4'd12, 4'd3,  4'd0};
    vecs[10] = '{0, OP_MAX, 4'd15, 4'd15, 4'd15};

    reset     = 1'b1;
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    for (int i = 0; i < 2; i++) begin
      req_op[i] = 2'b00;
      req_x[i]  = 4'd0;
      req_y[i]  = 4'd0;
    end
    step();
    step();
    do_reset();

    // Reset state
    check("rst_busy", busy, 0);
    check("rst_count", op_count, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_ready", req_ready, 0);
    check("rst_rsp0_data", rsp_data[0], 0);
    $display("reset: busy=%0d count=%0d", busy, op_count);

    // Reset while in EXEC discards the op
    req_valid[0] = 1'b1; req_op[0] = OP_MAX; req_x[0] = 4'd3; req_y[0] = 4'd4;
    rsp_ready = 2'b11;
    step();
    req_valid[0] = 1'b0;
    #1;
    check("mid_exec_busy", busy, 1);
    do_reset();
    check("mid_rst_busy", busy, 0);
    check("mid_rst_rsp", rsp_valid, 0);
    check("mid_rst_count", op_count, 0);
    step();
    check("mid_rst_rsp_later", rsp_valid, 0);
    check("mid_rst_count_later", op_count, 0);
    $display("reset mid-op: busy=%0d rsp_valid=%0d count=%0d", busy, rsp_valid, op_count);

    // Table of single ops
    for (int i = 0; i < 11; i++)
      do_op(vecs[i].id, vecs[i].op, vecs[i].x, vecs[i].y, vecs[i].exp_res, 1'b1);

    // Contention from reset: grants alternate 0,1,0,1
    do_reset();
    req_op[0] = OP_GT; req_x[0] = 4'd5; req_y[0] = 4'd2;   // owner 0 -> 1
    req_op[1] = OP_LT; req_x[1] = 4'd5; req_y[1] = 4'd2;   // owner 1 -> 0
    rsp_ready = 2'b11;
    req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      int own;
      own = k % 2;
      #1;
      check("cont_grant", req_ready, (own == 0) ? 1 : 2);
      step();
      check("cont_exec_ready", req_ready, 0);
      step();
      check("cont_rsp_owner", rsp_valid, (own == 0) ? 1 : 2);
      check("cont_rsp_data", rsp_data[own], (own == 0) ? 1 : 0);
      step();
      exp_count = exp_count + 8'd1;
      check("cont_count", op_count, exp_count);
      $display("contention: grant=%0d count=%0d", own, exp_count);
    end
    req_valid = 2'b00;

    // Backpressure on rsp0 while req1 waits (prio is 0 after owner 1 finished)
    req_valid = 2'b11;
    req_op[0] = OP_MAX; req_x[0] = 4'd2; req_y[0] = 4'd11;
    rsp_ready = 2'b10;                        // non-owner ready is ignored
    #1;
    check("bp_grant", req_ready, 1);
    step();
    req_valid[0] = 1'b0;
    step();
    for (int c = 0; c < 5; c++) begin
      check("bp_rsp_valid", rsp_valid, 1);
      check("bp_rsp_data", rsp_data[0], 11);
      check("bp_req1_ready", req_ready[1], 0);
      check("bp_busy", busy, 1);
      step();
    end
    rsp_ready = 2'b11;
    step();                                   // release edge
    exp_count = exp_count + 8'd1;
    check("bp_idle", busy, 0);
    check("bp_count", op_count, exp_count);
    check("bp_req1_now_ready", req_ready[1], 1);
    $display("backpressure: released, count=%0d", exp_count);

    // Requester drops valid before acceptance: nothing is queued
    req_valid[1] = 1'b0;
    #1;
    step();
    check("drop_no_grant", busy, 0);
    step();
    check("drop_no_rsp", rsp_valid, 0);
    $display("drop: busy=%0d", busy);

    // 256 completed ops wrap the counter
    do_reset();
    for (int n = 0; n < 256; n++)
      do_op(n % 2, OP_EQ, 4'd1, 4'd1, 4'd1, 1'b0);
    check("wrap_count", op_count, 0);
    $display("wrap: count=%0d after 256 ops", op_count);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
